// File: rtl/sram_unpack_read.sv
// sram_unpack_read: reads 64-bit SRAM words and streams them out as hi/lo 32-bit halves.
// Define SRAM_RD_CHECKSUM_EN to add a running 32-bit checksum of accepted words.
module sram_unpack_read #(
    parameter int RD_LAT = 2,
    parameter int CNT_W  = 20
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             enable,
    input  logic             start,
    input  logic [18:0]      start_addr,
    input  logic [CNT_W-1:0] word_count,
    output logic [18:0]      SRAM_ADDR_Stream,
    output logic             SRAM_RD_EN,
    input  logic [63:0]      SRAM_DATA_OUT_Stream,
    output logic [31:0]      data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
`ifdef SRAM_RD_CHECKSUM_EN
    output logic [31:0]      checksum,
`endif
    output logic             done
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] ISSUE   = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] EMIT_HI = 3'd3;
    localparam logic [2:0] EMIT_LO = 3'd4;
    localparam logic [2:0] FIN     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [18:0]      addr_q, addr_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       lat_q, lat_d;
    logic [63:0]      buf_q, buf_d;
    logic             clr;

    // enable low acts exactly like reset, aborting any transfer silently
    assign clr = !RSTn || !enable;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        lat_d   = lat_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: if (start) begin
                addr_d  = start_addr;
                rem_d   = word_count;
                state_d = (word_count == '0) ? FIN : ISSUE;
            end
            ISSUE: begin
                lat_d   = 3'(RD_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                lat_d = lat_q - 3'd1;
                if (lat_q == 3'd1) begin
                    buf_d   = SRAM_DATA_OUT_Stream;
                    state_d = EMIT_HI;
                end
            end
            EMIT_HI: if (data_ready) state_d = EMIT_LO;
            EMIT_LO: if (data_ready) begin
                rem_d   = rem_q - CNT_W'(1);
                addr_d  = addr_q + 19'd1;
                state_d = (rem_q == CNT_W'(1)) ? FIN : ISSUE;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (clr) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            lat_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            lat_q   <= lat_d;
            buf_q   <= buf_d;
        end
    end

    assign SRAM_ADDR_Stream = addr_q;
    assign SRAM_RD_EN       = state_q == ISSUE;
    assign data_valid       = (state_q == EMIT_HI) || (state_q == EMIT_LO);
    assign data_out         = (state_q == EMIT_HI) ? buf_q[63:32] :
                              (state_q == EMIT_LO) ? buf_q[31:0] : '0;
    assign busy             = state_q != IDLE;
    assign done             = state_q == FIN;

`ifdef SRAM_RD_CHECKSUM_EN
    logic [31:0] cks_q, cks_d;

    assign cks_d = (state_q == IDLE && start) ? '0 :
                   (data_valid && data_ready) ? cks_q + data_out : cks_q;

    always_ff @(posedge CLK) begin
        if (clr) cks_q <= '0;
        else     cks_q <= cks_d;
    end

    assign checksum = cks_q;
`endif
endmodule

// File: tb/tb_sram_unpack_read.sv
// tb_sram_unpack_read: randomized and directed checks of sram_unpack_read against a queue-based model.
module tb_sram_unpack_read;
    localparam int RD_LAT = 2;
    localparam int CNT_W  = 20;

    logic             CLK = 0, RSTn = 0, enable = 1, start = 0, data_ready = 0;
    logic [18:0]      start_addr = '0;
    logic [CNT_W-1:0] word_count = '0;
    logic [18:0]      SRAM_ADDR_Stream;
    logic             SRAM_RD_EN;
    logic [63:0]      SRAM_DATA_OUT_Stream = '0;
    logic [31:0]      data_out;
    logic             data_valid, busy, done;
`ifdef SRAM_RD_CHECKSUM_EN
    logic [31:0]      checksum;
`endif
    logic [54:0]      outs;

    sram_unpack_read #(.RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RSTn(RSTn), .enable(enable), .start(start),
        .start_addr(start_addr), .word_count(word_count),
        .SRAM_ADDR_Stream(SRAM_ADDR_Stream), .SRAM_RD_EN(SRAM_RD_EN),
        .SRAM_DATA_OUT_Stream(SRAM_DATA_OUT_Stream),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .busy(busy),
`ifdef SRAM_RD_CHECKSUM_EN
        .checksum(checksum),
`endif
        .done(done)
    );

    always #5 CLK = ~CLK;
    assign outs = {SRAM_ADDR_Stream, SRAM_RD_EN, data_out, data_valid, busy, done};

    int tests = 0, fails = 0, cyc = 0, rd_cnt = 0, word_cnt = 0, done_cnt = 0;
    logic [63:0] mem [int];
    logic [31:0] exp_q [$];
    logic [18:0] exp_a [$];
    logic [31:0] exp_sum = '0;
    logic        pend_v = 0, hold_v = 0;
    int          pend_c = 0;
    logic [18:0] pend_a = '0;
    logic [31:0] hold_d = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd(input logic [18:0] a);
        logic [31:0] x;
        x = {13'd0, a};
        if (mem.exists(int'(a))) return mem[int'(a)];
        return {x * 32'h9E3779B1 + 32'h0BADF00D, x ^ 32'hA5A50000 ^ (x << 13)};
    endfunction

    // SRAM: data is present only in the cycle RD_LAT after the strobe, junk otherwise
    always @(posedge CLK) begin
        #1;
        cyc++;
        if (pend_v && pend_c == cyc) begin
            SRAM_DATA_OUT_Stream = rd(pend_a);
            pend_v = 0;
        end else SRAM_DATA_OUT_Stream = {$urandom, $urandom};
        if (SRAM_RD_EN === 1'b1) begin
            rd_cnt++;
            pend_v = 1;
            pend_c = cyc + RD_LAT;
            pend_a = SRAM_ADDR_Stream;
            if (exp_a.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_addr", SRAM_ADDR_Stream, exp_a.pop_front());
        end
    end

    always @(negedge CLK) begin
        if (hold_v) chk("hold_stable", {data_valid, data_out}, {1'b1, hold_d});
        hold_v = data_valid && !data_ready && RSTn && enable;
        hold_d = data_out;
        if (done === 1'b1) done_cnt++;
        if (data_valid && data_ready && RSTn && enable) begin
            word_cnt++;
            if (exp_q.size() == 0) chk("word_unexpected", 1, 0);
            else chk("word", data_out, exp_q.pop_front());
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic launch(input logic [18:0] a, input int n);
        logic [18:0] w;
        logic [63:0] d;
        exp_sum = '0;
        for (int i = 0; i < n; i++) begin
            w = a + 19'(i);
            d = rd(w);
            exp_a.push_back(w);
            exp_q.push_back(d[63:32]);
            exp_q.push_back(d[31:0]);
            exp_sum = exp_sum + d[63:32] + d[31:0];
        end
        step();
        start = 1; start_addr = a; word_count = CNT_W'(n);
        step();
        start = 0;
    endtask

    task automatic finish_xfer(input int pct, input logic [18:0] end_a);
        bit seen;
        seen = 0;
        for (int k = 0; k < 3000; k++) begin
            data_ready = ($urandom_range(0, 99) < pct);
            @(negedge CLK);
            if (done === 1'b1) begin seen = 1; break; end
            step();
        end
        chk("done_seen", seen, 1);
        chk("done_busy", busy, 1);
        chk("end_addr", SRAM_ADDR_Stream, end_a);
`ifdef SRAM_RD_CHECKSUM_EN
        chk("checksum", checksum, exp_sum);
`endif
        chk("words_left", exp_q.size(), 0);
        chk("addrs_left", exp_a.size(), 0);
        exp_q.delete();
        exp_a.delete();
        step();
        @(negedge CLK);
        chk("idle_after_done", {busy, done}, 0);
        step();
    endtask

    task automatic flush();
        exp_q.delete();
        exp_a.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, w0, d0;
        logic [18:0] a;
        int n;
        repeat (3) step();
        @(negedge CLK);
        chk("por_outs", outs, 0);
        step();
        RSTn = 1;
        step();

        // reset mid-transfer
        data_ready = 1;
        launch(19'h01234, 8);
        repeat (8) step();
        d0 = done_cnt;
        RSTn = 0;
        step();
        @(negedge CLK);
        chk("rst_outs", outs, 0);
        step();
        step();
        RSTn = 1;
        @(negedge CLK);
        chk("rst_outs_end", outs, 0);
        step();
        @(negedge CLK);
        chk("rst_released_idle", outs, 0);
        chk("rst_no_done", done_cnt, d0);
        flush();
        step();

        // single word, exact cycle timing
        mem[32'h10] = 64'h11112222_33334444;
        data_ready = 1;
        launch(19'h00010, 1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            chk($sformatf("t2_rden_c%0d", k), SRAM_RD_EN, k == 1);
            chk($sformatf("t2_valid_c%0d", k), data_valid, (k == 4) || (k == 5));
            chk($sformatf("t2_done_c%0d", k), done, k == 6);
            if (k == 1) chk("t2_addr_c1", SRAM_ADDR_Stream, 19'h00010);
            if (k == 4) chk("t2_hi_c4", data_out, 32'h11112222);
            if (k == 5) chk("t2_lo_c5", data_out, 32'h33334444);
            if (k == 6) chk("t2_addr_c6", SRAM_ADDR_Stream, 19'h00011);
            step();
        end
        chk("t2_left", exp_q.size(), 0);
        step();

        // backpressure in EMIT_HI
        r0 = rd_cnt;
        w0 = word_cnt;
        data_ready = 0;
        launch(19'h02000, 2);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (data_valid) break;
            step();
        end
        chk("bp_valid", data_valid, 1);
        repeat (3) begin
            step();
            @(negedge CLK);
            chk("bp_valid_hold", data_valid, 1);
        end
        step();
        finish_xfer(100, 19'h02002);
        chk("bp_rd_pulses", rd_cnt - r0, 2);
        chk("bp_words", word_cnt - w0, 4);

        // address wrap, then zero count
        launch(19'h7FFFF, 2);
        finish_xfer(70, 19'h00001);
        r0 = rd_cnt;
        w0 = word_cnt;
        d0 = done_cnt;
        data_ready = 1;
        launch(19'h00005, 0);
        @(negedge CLK);
        chk("zero_done", done, 1);
        chk("zero_addr", SRAM_ADDR_Stream, 19'h00005);
        step();
        @(negedge CLK);
        chk("zero_idle", {busy, done}, 0);
        step();
        step();
        chk("zero_no_rd", rd_cnt - r0, 0);
        chk("zero_no_word", word_cnt - w0, 0);
        chk("zero_one_done", done_cnt - d0, 1);

        // ignored start while busy, then abort during WAIT of word 3
        r0 = rd_cnt;
        d0 = done_cnt;
        data_ready = 1;
        launch(19'h03000, 8);
        start = 1; start_addr = 19'h55555; word_count = CNT_W'(3);
        step();
        start = 0;
        for (int k = 0; k < 200 && rd_cnt < r0 + 3; k++) step();
        chk("ab_reach_word3", rd_cnt - r0, 3);
        step();
        enable = 0;
        step();
        enable = 1;
        @(negedge CLK);
        chk("ab_outs", outs, 0);
        step();
        @(negedge CLK);
        chk("ab_outs_idle", outs, 0);
        chk("ab_no_done", done_cnt, d0);
        flush();
        step();

        // known checksum words
        mem[32'h100] = 64'h00000001_FFFFFFFF;
        mem[32'h101] = 64'h00000002_00000003;
        launch(19'h00100, 2);
        finish_xfer(60, 19'h00102);
`ifdef SRAM_RD_CHECKSUM_EN
        chk("cks_known", checksum, 32'h5);
`endif

        // randomized transfers
        repeat (25) begin
            a = ($urandom_range(0, 3) == 0) ? 19'h7FFFC + 19'($urandom_range(0, 3)) : 19'($urandom);
            n = $urandom_range(0, 5);
            launch(a, n);
            finish_xfer($urandom_range(30, 100), a + 19'(n));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
